// File: rtl/i2s_pkg.sv
// i2s_pkg: shared framing constants and slot helpers for the I2S transmitter.
package i2s_pkg;

    localparam int unsigned SLOT_W            = 32;
    localparam int unsigned FRAME_BITS        = 64;
    localparam int unsigned IDX_W             = 6;
    localparam int unsigned FRAME_LOAD_IDX    = 0;
    localparam int unsigned SLOT_BOUNDARY_IDX = 32;

    typedef enum logic {
        SLOT_LEFT  = 1'b0,
        SLOT_RIGHT = 1'b1
    } slot_e;

    // Place a zero-extended sample in a slot so that slot index 0 sits at the MSB.
    function automatic logic [SLOT_W-1:0] slot_image(input logic [SLOT_W-1:0] sample,
                                                     input int unsigned        shift);
        return sample << shift;
    endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// i2s_clk_gen: divides clk down to bit_clk and flags the cycles before each bit_clk edge.
module i2s_clk_gen #(
    parameter int unsigned BCLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic bit_clk,
    output logic fall_tick,
    output logic rise_tick
);

    localparam int unsigned DIV_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
    localparam int unsigned HALF  = BCLK_DIV / 2;

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_cnt_nxt;

    always_comb begin
        div_cnt_nxt = div_cnt + DIV_W'(1);
        if (div_cnt == DIV_W'(BCLK_DIV - 1)) begin
            div_cnt_nxt = '0;
        end
    end

    // Ticks mark the cycle at whose end bit_clk falls (div_cnt wraps) or rises.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt   <= '0;
            bit_clk   <= 1'b0;
            fall_tick <= 1'b0;
            rise_tick <= 1'b0;
        end else begin
            div_cnt   <= div_cnt_nxt;
            bit_clk   <= (div_cnt_nxt >= DIV_W'(HALF));
            fall_tick <= (div_cnt_nxt == DIV_W'(BCLK_DIV - 1));
            rise_tick <= (div_cnt_nxt == DIV_W'(HALF - 1));
        end
    end

endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: stereo PCM serializer with a one-pair holding register and underrun flag.
// Build option: define I2S_TX_LJ_FORMAT_EN for left-justified framing (MSB at slot index 0).
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned BCLK_DIV = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] sample_l,
    input  logic [SAMPLE_W-1:0] sample_r,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                bit_clk,
    output logic                frame_clk,
    output logic                sdata,
    output logic                underrun
);

`ifdef I2S_TX_LJ_FORMAT_EN
    localparam int unsigned IMG_SHIFT = SLOT_W - SAMPLE_W;
`else
    localparam int unsigned IMG_SHIFT = SLOT_W - 1 - SAMPLE_W;
`endif

    logic fall_tick;
    logic unused_rise_tick;

    logic [IDX_W-1:0]    bit_idx;
    logic [IDX_W-1:0]    bit_idx_nxt;
    logic [IDX_W-1:0]    bit_idx_inc;
    logic [SAMPLE_W-1:0] hold_l;
    logic [SAMPLE_W-1:0] hold_r;
    logic [SAMPLE_W-1:0] hold_l_nxt;
    logic [SAMPLE_W-1:0] hold_r_nxt;
    logic [SAMPLE_W-1:0] last_l;
    logic [SAMPLE_W-1:0] last_r;
    logic [SAMPLE_W-1:0] last_l_nxt;
    logic [SAMPLE_W-1:0] last_r_nxt;
    logic [SAMPLE_W-1:0] src_l;
    logic [SAMPLE_W-1:0] src_r;
    logic [SLOT_W-1:0]   sh_l;
    logic [SLOT_W-1:0]   sh_r;
    logic [SLOT_W-1:0]   sh_l_nxt;
    logic [SLOT_W-1:0]   sh_r_nxt;
    logic                hold_full;
    logic                hold_full_nxt;
    logic                accept;
    logic                frame_load;
    logic                slot_switch;
    logic                frame_clk_nxt;
    logic                sdata_nxt;
    logic                underrun_nxt;

    i2s_clk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_clk_gen (
        .clk       (clk),
        .reset     (reset),
        .bit_clk   (bit_clk),
        .fall_tick (fall_tick),
        .rise_tick (unused_rise_tick)
    );

    assign hold_full   = !sample_ready;
    assign accept      = sample_valid && sample_ready;
    assign bit_idx_inc = bit_idx + IDX_W'(1);
    assign frame_load  = fall_tick && (bit_idx_inc == IDX_W'(FRAME_LOAD_IDX));
    assign slot_switch = fall_tick && (bit_idx_inc == IDX_W'(SLOT_BOUNDARY_IDX));

    // An empty holding register at frame load repeats the previously played pair.
    assign src_l = hold_full ? hold_l : last_l;
    assign src_r = hold_full ? hold_r : last_r;

    always_comb begin
        bit_idx_nxt   = bit_idx;
        hold_l_nxt    = hold_l;
        hold_r_nxt    = hold_r;
        hold_full_nxt = hold_full;
        last_l_nxt    = last_l;
        last_r_nxt    = last_r;
        sh_l_nxt      = sh_l;
        sh_r_nxt      = sh_r;
        frame_clk_nxt = frame_clk;
        sdata_nxt     = sdata;
        underrun_nxt  = 1'b0;

        if (frame_load) begin
            hold_full_nxt = 1'b0;
        end
        // Accept is only possible while empty, so it never collides with a full-register load.
        if (accept) begin
            hold_l_nxt    = sample_l;
            hold_r_nxt    = sample_r;
            hold_full_nxt = 1'b1;
        end

        if (fall_tick) begin
            bit_idx_nxt = bit_idx_inc;
            if (frame_load) begin
                sh_l_nxt      = slot_image(SLOT_W'(src_l), IMG_SHIFT);
                sh_r_nxt      = slot_image(SLOT_W'(src_r), IMG_SHIFT);
                last_l_nxt    = src_l;
                last_r_nxt    = src_r;
                sdata_nxt     = sh_l_nxt[SLOT_W-1];
                frame_clk_nxt = SLOT_LEFT;
                underrun_nxt  = !hold_full;
            end else if (slot_switch) begin
                sdata_nxt     = sh_r[SLOT_W-1];
                frame_clk_nxt = SLOT_RIGHT;
            end else if (!bit_idx[IDX_W-1]) begin
                sdata_nxt = sh_l[SLOT_W-2];
                sh_l_nxt  = sh_l << 1;
            end else begin
                sdata_nxt = sh_r[SLOT_W-2];
                sh_r_nxt  = sh_r << 1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_idx      <= '0;
            hold_l       <= '0;
            hold_r       <= '0;
            last_l       <= '0;
            last_r       <= '0;
            sh_l         <= '0;
            sh_r         <= '0;
            sample_ready <= 1'b1;
            frame_clk    <= 1'b0;
            sdata        <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            bit_idx      <= bit_idx_nxt;
            hold_l       <= hold_l_nxt;
            hold_r       <= hold_r_nxt;
            last_l       <= last_l_nxt;
            last_r       <= last_r_nxt;
            sh_l         <= sh_l_nxt;
            sh_r         <= sh_r_nxt;
            sample_ready <= !hold_full_nxt;
            frame_clk    <= frame_clk_nxt;
            sdata        <= sdata_nxt;
            underrun     <= underrun_nxt;
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: frame table, corner-case sequences and random traffic against a cycle-count reference model.
module tb_i2s_tx;

    localparam int unsigned W   = 16;
    localparam int unsigned DIV = 4;
    localparam int unsigned FC  = DIV * 64;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] sample_l = '0;
    logic [W-1:0] sample_r = '0;
    logic         sample_valid = 1'b0;
    logic         sample_ready;
    logic         bit_clk;
    logic         frame_clk;
    logic         sdata;
    logic         underrun;

    always #5 clk = ~clk;

    i2s_tx #(
        .SAMPLE_W (W),
        .BCLK_DIV (DIV)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .bit_clk      (bit_clk),
        .frame_clk    (frame_clk),
        .sdata        (sdata),
        .underrun     (underrun)
    );

    typedef struct {
        logic [W-1:0] l;
        logic [W-1:0] r;
        logic [63:0]  frame;
    } vec_t;

    vec_t tbl[5];

    int checks = 0;
    int failures = 0;

    // Reference model: cycle count since reset plus holding/playing pairs.
    int           c = 0;
    logic         m_full = 1'b0;
    logic [W-1:0] h_l = '0, h_r = '0, cur_l = '0, cur_r = '0;
    logic         exp_ur = 1'b0;
    int           acc_cnt = 0;
    int           acc_cycle = 0;

    logic [63:0]  cap = '0;
    logic [63:0]  frames [int];
    int           ur_seen = 0, fclk_toggles = 0, ones_seen = 0;
    logic         prev_fclk = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [W-1:0] l, input logic [W-1:0] r, input int b);
        logic [W-1:0] x;
        int s;
        x = (b < 32) ? l : r;
        s = b % 32;
`ifdef I2S_TX_LJ_FORMAT_EN
        if (s < int'(W)) return x[W-1-s];
`else
        if (s >= 1 && s <= int'(W)) return x[W-s];
`endif
        return 1'b0;
    endfunction

    task automatic model_edge();
        logic acc;
        if (reset) begin
            c = 0; m_full = 1'b0; h_l = '0; h_r = '0;
            cur_l = '0; cur_r = '0; exp_ur = 1'b0;
            frames.delete();
        end else begin
            acc = sample_valid && !m_full;
            exp_ur = 1'b0;
            if ((c + 1) % FC == 0) begin
                if (m_full) begin
                    cur_l = h_l; cur_r = h_r;
                end else begin
                    exp_ur = 1'b1;
                end
                m_full = 1'b0;
            end
            if (acc) begin
                h_l = sample_l; h_r = sample_r; m_full = 1'b1;
                acc_cnt++; acc_cycle = c;
            end
            c++;
        end
    endtask

    task automatic monitor();
        int b, dv;
        logic [4:0] e;
        b  = (c / DIV) % 64;
        dv = c % DIV;
        e  = {dv >= int'(DIV / 2), b >= 32, exp_bit(cur_l, cur_r, b), !m_full, exp_ur};
        check($sformatf("cycle %0d {bclk,fclk,sdata,ready,underrun}", c),
              64'({bit_clk, frame_clk, sdata, sample_ready, underrun}), 64'(e));
        if (underrun === 1'b1) ur_seen++;
        if (frame_clk !== prev_fclk) fclk_toggles++;
        prev_fclk = frame_clk;
        if (sdata === 1'b1) ones_seen++;
        if (!reset && dv == int'(DIV / 2)) begin
            cap[63-b] = sdata;
            if (b == 63) frames[c / FC] = cap;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        monitor();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_to(input int target);
        while (c < target) tick();
    endtask

    task automatic offer(input logic [W-1:0] l, input logic [W-1:0] r, output int frame);
        int n0, k;
        n0 = acc_cnt;
        k = 0;
        sample_valid = 1'b1; sample_l = l; sample_r = r;
        while (acc_cnt == n0 && k < 2 * int'(FC)) begin
            tick();
            k++;
        end
        sample_valid = 1'b0;
        check("offer accepted", 64'(acc_cnt != n0), 64'd1);
        frame = acc_cycle / FC;
    endtask

    task automatic check_frame(input string name, input int f, input logic [63:0] exp);
        logic [63:0] a;
        a = 'x;
        if (frames.exists(f)) a = frames[f];
        check(name, a, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " bit_clk"}, 64'(bit_clk), 64'd0);
        check({tag, " frame_clk"}, 64'(frame_clk), 64'd0);
        check({tag, " sdata"}, 64'(sdata), 64'd0);
        check({tag, " sample_ready"}, 64'(sample_ready), 64'd1);
        check({tag, " underrun"}, 64'(underrun), 64'd0);
    endtask

    initial begin
        int pf[5];
        int p, fl, hi_cnt;

`ifdef I2S_TX_LJ_FORMAT_EN
        tbl[0] = '{16'h8001, 16'h7FFE, 64'h8001_0000_7FFE_0000};
        tbl[1] = '{16'hFFFF, 16'h0000, 64'hFFFF_0000_0000_0000};
        tbl[2] = '{16'h0000, 16'hFFFF, 64'h0000_0000_FFFF_0000};
        tbl[3] = '{16'hC000, 16'h0001, 64'hC000_0000_0001_0000};
        tbl[4] = '{16'h1234, 16'hABCD, 64'h1234_0000_ABCD_0000};
`else
        tbl[0] = '{16'h8001, 16'h7FFE, 64'h4000_8000_3FFF_0000};
        tbl[1] = '{16'hFFFF, 16'h0000, 64'h7FFF_8000_0000_0000};
        tbl[2] = '{16'h0000, 16'hFFFF, 64'h0000_0000_7FFF_8000};
        tbl[3] = '{16'hC000, 16'h0001, 64'h6000_0000_0000_8000};
        tbl[4] = '{16'h1234, 16'hABCD, 64'h091A_0000_55E6_8000};
`endif

        // Reset, then two idle frames.
        run(3);
        check_reset_outputs("reset");
        reset = 1'b0;
        ur_seen = 0; fclk_toggles = 0; ones_seen = 0; prev_fclk = frame_clk;
        run(2 * FC);
        check("idle underrun pulses", 64'(ur_seen), 64'd2);
        check("idle frame_clk toggles", 64'(fclk_toggles), 64'd4);
        check("idle sdata ones", 64'(ones_seen), 64'd0);

        // Back-to-back pairs, one per frame.
        ur_seen = 0;
        for (int i = 0; i < 5; i++) begin
            offer(tbl[i].l, tbl[i].r, p);
            pf[i] = p + 1;
        end
        run_to((pf[4] + 1) * FC - 1);
        for (int i = 0; i < 5; i++) check_frame($sformatf("table frame %0d", i), pf[i], tbl[i].frame);
        check("streaming underruns", 64'(ur_seen), 64'd0);

        // Valid held high while full: later inputs must be ignored.
        run_to((c / FC + 1) * FC);
        offer(tbl[4].l, tbl[4].r, p);
        hi_cnt = 0;
        sample_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            sample_l = W'($urandom); sample_r = W'($urandom);
            tick();
            if (sample_ready !== 1'b0) hi_cnt++;
        end
        sample_valid = 1'b0;
        check("ready low while full", 64'(hi_cnt), 64'd0);
        run_to((p + 2) * FC - 1);
        check_frame("held pair frame", p + 1, tbl[4].frame);

        // Offer on the frame-load cycle with holding empty.
        sample_valid = 1'b1; sample_l = tbl[1].l; sample_r = tbl[1].r;
        tick();
        sample_valid = 1'b0;
        check("underrun on load-cycle offer", 64'(underrun), 64'd1);
        fl = c / FC;
        run_to((fl + 2) * FC - 1);
        check_frame("repeat-last frame", fl, tbl[4].frame);
        check_frame("load-cycle pair frame", fl + 1, tbl[1].frame);

        // Reset at bit_idx 40 with a full holding register.
        run_to((c / FC + 1) * FC);
        offer(tbl[2].l, tbl[2].r, p);
        run_to((c / FC) * FC + 40 * DIV);
        reset = 1'b1;
        tick();
        check_reset_outputs("mid-frame reset");
        reset = 1'b0;
        run_to(2 * FC - 1);
        check_frame("post-reset frame 0", 0, 64'd0);
        check_frame("post-reset frame 1", 1, 64'd0);

        // Random traffic.
        for (int i = 0; i < 8 * int'(FC); i++) begin
            sample_valid = ($urandom_range(0, 3) == 0);
            sample_l = W'($urandom); sample_r = W'($urandom);
            tick();
        end
        sample_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
